// File: rtl/mem_stage.sv
// mem_stage -- memory-access stage of the 5-stage MIPS pipeline.
// Issues loads/stores to data memory over a req/ack handshake and stalls the
// upstream pipeline while an access is outstanding. It also resolves the
// branch decision and holds the MEM/WB stage register.
//
// Optional feature macro: MEM_TIMEOUT_EN. When defined, an access that sees no
// ack for TIMEOUT_CYCLES request cycles is aborted and the sticky mem_err is
// set. When undefined, WAIT lasts until ack and mem_err is tied to 0.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   Branch_in .. Zero_in      EX/MEM control bits
//   ALU_in, Reg2_in           address / ALU result, store data
//   WriteReg_in               destination register
//   dmem_req/we/addr/wdata    data-memory request (combinational)
//   dmem_ack, dmem_rdata      data-memory response
//   Stall                     freeze PC, IF/ID, ID/EX, EX/MEM (combinational)
//   PCSrc                     branch taken (combinational)
//   RegWrite_out .. WriteReg_out  MEM/WB register
//   mem_err                   sticky access-timeout flag
module mem_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Branch_in,
  input  logic        MemRead_in,
  input  logic        MemWrite_in,
  input  logic        RegWrite_in,
  input  logic        Mem2Reg_in,
  input  logic        Zero_in,
  input  logic [31:0] ALU_in,
  input  logic [31:0] Reg2_in,
  input  logic [4:0]  WriteReg_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        Stall,
  output logic        PCSrc,
  output logic        RegWrite_out,
  output logic        Mem2Reg_out,
  output logic [31:0] MemData_out,
  output logic [31:0] ALU_out,
  output logic [4:0]  WriteReg_out,
  output logic        mem_err
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("mem_stage: TIMEOUT_CYCLES must be in 1..255");
  end

`ifdef MEM_TIMEOUT_EN
  typedef enum logic [1:0] {IDLE, WAIT, ABORT} state_t;
  localparam logic [7:0] LIMIT = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] cnt;
  logic       at_limit;
  assign at_limit = (cnt == LIMIT);
`else
  typedef enum logic [1:0] {IDLE, WAIT} state_t;
  assign mem_err = 1'b0;
`endif

  state_t state;
  logic   access;
  logic   is_load;
  logic   in_abort;

  assign access  = MemRead_in | MemWrite_in;
  // A simultaneous read+write is treated as a store, so no load data is kept.
  assign is_load = MemRead_in & ~MemWrite_in;

`ifdef MEM_TIMEOUT_EN
  assign in_abort = (state == ABORT);
`else
  assign in_abort = 1'b0;
`endif

  // Request is gated by rst so a reset mid-access drops it in the same cycle.
  always_comb begin
    dmem_req = 1'b0;
    if (!rst) begin
      case (state)
        IDLE:    dmem_req = access;
        WAIT:    dmem_req = 1'b1;
        default: dmem_req = 1'b0;
      endcase
    end
  end

  // EX/MEM is frozen by Stall, so these stay stable while a request pends.
  assign dmem_we    = MemWrite_in;
  assign dmem_addr  = ALU_in;
  assign dmem_wdata = Reg2_in;
  assign Stall      = dmem_req & ~dmem_ack;
  assign PCSrc      = ~rst & Branch_in & Zero_in;

  // Handshake FSM, timeout counter and MEM/WB register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      RegWrite_out <= 1'b0;
      Mem2Reg_out  <= 1'b0;
      MemData_out  <= 32'b0;
      ALU_out      <= 32'b0;
      WriteReg_out <= 5'b0;
`ifdef MEM_TIMEOUT_EN
      cnt          <= 8'd0;
      mem_err      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (access && !dmem_ack) begin
`ifdef MEM_TIMEOUT_EN
            cnt <= cnt + 8'd1;
            if (at_limit) begin
              state   <= ABORT;
              mem_err <= 1'b1;
            end else begin
              state <= WAIT;
            end
`else
            state <= WAIT;
`endif
          end
        end
        WAIT: begin
          if (dmem_ack) begin
            state <= IDLE;
`ifdef MEM_TIMEOUT_EN
            cnt   <= 8'd0;
`endif
          end else begin
`ifdef MEM_TIMEOUT_EN
            cnt <= cnt + 8'd1;
            if (at_limit) begin
              state   <= ABORT;
              mem_err <= 1'b1;
            end
`endif
          end
        end
        default: begin
          state <= IDLE;
`ifdef MEM_TIMEOUT_EN
          cnt   <= 8'd0;
`endif
        end
      endcase

      // Stall or abort inserts a bubble; other MEM/WB fields hold.
      if (Stall || in_abort) begin
        RegWrite_out <= 1'b0;
      end else begin
        RegWrite_out <= RegWrite_in;
        Mem2Reg_out  <= Mem2Reg_in;
        ALU_out      <= ALU_in;
        WriteReg_out <= WriteReg_in;
        MemData_out  <= is_load ? dmem_rdata : 32'b0;
      end
    end
  end

endmodule
